// File: rtl/trashbin_mem_sequencer.sv
// Memory access sequencer for the Trashbin core: one request/response port
// shared by fetch, load and store, driving a strobe/OK memory bus.
//
// Ports:
//   CoreClock, Reset           clock, asynchronous active-high reset
//   Req*                       request side (valid/ready, write, size, signed,
//                              byte address, right-aligned store data)
//   Resp*                      one-cycle response pulse with data and error code
//   AddressBus, DataWriteBus   word address and lane-replicated store data
//   ByteEnable                 active byte lanes
//   ReadAssert, WriteAssert    bus strobes, held until the matching OK
//   DataReadBus, ReadOK,
//   WriteOK                    memory read data and completion handshakes
module trashbin_mem_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CoreClock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [31:0]           ReqWriteData,
    output logic                  RespValid,
    output logic [31:0]           RespData,
    output logic                  RespError,
    output logic [1:0]            RespErrorCode,
    output logic [ADDR_WIDTH-1:0] AddressBus,
    output logic [31:0]           DataWriteBus,
    output logic [3:0]            ByteEnable,
    output logic                  ReadAssert,
    output logic                  WriteAssert,
    input  logic [31:0]           DataReadBus,
    input  logic                  ReadOK,
    input  logic                  WriteOK
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_write;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_ok;
    logic          w_timeout;

    assign ReqReady  = (r_state == S_IDLE);
    assign w_ok      = r_write ? WriteOK : ReadOK;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // Request checks; illegal size outranks misalignment.
    always_comb begin
        w_err = 2'd0;
        if (ReqSize == 2'd3)
            w_err = 2'd3;
        else if (ReqSize == 2'd1 && ReqAddress[0])
            w_err = 2'd1;
        else if (ReqSize == 2'd2 && ReqAddress[1:0] != 2'b00)
            w_err = 2'd1;
    end

    always_comb begin
        w_be    = 4'hF;
        w_wdata = ReqWriteData;
        unique case (ReqSize)
            2'd0: begin
                w_be    = 4'b0001 << ReqAddress[1:0];
                w_wdata = {4{ReqWriteData[7:0]}};
            end
            2'd1: begin
                w_be    = 4'b0011 << ReqAddress[1:0];
                w_wdata = {2{ReqWriteData[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = ReqWriteData;
            end
        endcase
    end

    // Lane extraction and extension for loads, from registered request info.
    always_comb begin
        w_byte = 8'h00;
        unique case (r_off)
            2'd0: w_byte = DataReadBus[7:0];
            2'd1: w_byte = DataReadBus[15:8];
            2'd2: w_byte = DataReadBus[23:16];
            default: w_byte = DataReadBus[31:24];
        endcase
        w_half = r_off[1] ? DataReadBus[31:16] : DataReadBus[15:0];
        w_load = DataReadBus;
        unique case (r_size)
            2'd0: w_load = r_signed ? {{24{w_byte[7]}}, w_byte}
                                    : {24'h0, w_byte};
            2'd1: w_load = r_signed ? {{16{w_half[15]}}, w_half}
                                    : {16'h0, w_half};
            default: w_load = DataReadBus;
        endcase
    end

    always_ff @(posedge CoreClock or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_off         <= 2'd0;
            r_size        <= 2'd0;
            r_signed      <= 1'b0;
            r_write       <= 1'b0;
            r_cnt         <= '0;
            RespValid     <= 1'b0;
            RespData      <= 32'h0;
            RespError     <= 1'b0;
            RespErrorCode <= 2'd0;
            AddressBus    <= '0;
            DataWriteBus  <= 32'h0;
            ByteEnable    <= 4'h0;
            ReadAssert    <= 1'b0;
            WriteAssert   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (ReqValid) begin
                        if (w_err != 2'd0) begin
                            r_state       <= S_RESP;
                            RespValid     <= 1'b1;
                            RespError     <= 1'b1;
                            RespErrorCode <= w_err;
                            RespData      <= 32'h0;
                        end else begin
                            r_state      <= S_ACCESS;
                            r_off        <= ReqAddress[1:0];
                            r_size       <= ReqSize;
                            r_signed     <= ReqSigned;
                            r_write      <= ReqWrite;
                            r_cnt        <= '0;
                            AddressBus   <= {ReqAddress[ADDR_WIDTH-1:2], 2'b00};
                            ByteEnable   <= w_be;
                            DataWriteBus <= w_wdata;
                            ReadAssert   <= ~ReqWrite;
                            WriteAssert  <= ReqWrite;
                        end
                    end
                end
                S_ACCESS: begin
                    // OK beats a coinciding timeout.
                    if (w_ok) begin
                        r_state     <= S_RESP;
                        ReadAssert  <= 1'b0;
                        WriteAssert <= 1'b0;
                        RespValid   <= 1'b1;
                        RespData    <= r_write ? 32'h0 : w_load;
                    end else if (w_timeout) begin
                        r_state       <= S_RESP;
                        ReadAssert    <= 1'b0;
                        WriteAssert   <= 1'b0;
                        RespValid     <= 1'b1;
                        RespError     <= 1'b1;
                        RespErrorCode <= 2'd2;
                        RespData      <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state       <= S_IDLE;
                    RespValid     <= 1'b0;
                    RespError     <= 1'b0;
                    RespErrorCode <= 2'd0;
                    RespData      <= 32'h0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trashbin_mem_sequencer.sv
// Bench for trashbin_mem_sequencer: directed cases then randomized requests,
// checked against a byte-level model of the access rules.
module tb_trashbin_mem_sequencer;

    localparam int AW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          ReqValid, ReqReady, ReqWrite, ReqSigned;
    logic [1:0]    ReqSize;
    logic [AW-1:0] ReqAddress;
    logic [31:0]   ReqWriteData;
    logic          RespValid, RespError;
    logic [31:0]   RespData;
    logic [1:0]    RespErrorCode;
    logic [AW-1:0] AddressBus;
    logic [31:0]   DataWriteBus;
    logic [3:0]    ByteEnable;
    logic          ReadAssert, WriteAssert;
    logic [31:0]   DataReadBus;
    logic          ReadOK, WriteOK;

    int n_cmp = 0;
    int n_bad = 0;

    trashbin_mem_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .CoreClock(clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
        .ReqWriteData(ReqWriteData),
        .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
        .RespErrorCode(RespErrorCode),
        .AddressBus(AddressBus), .DataWriteBus(DataWriteBus),
        .ByteEnable(ByteEnable), .ReadAssert(ReadAssert),
        .WriteAssert(WriteAssert), .DataReadBus(DataReadBus),
        .ReadOK(ReadOK), .WriteOK(WriteOK)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_err(input logic [1:0] sz,
                                         input logic [31:0] a);
        int nb;
        if (sz == 2'd3) return 2'd3;
        nb = 1 << sz;
        if ((a % nb) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz,
                                        input logic [31:0] a);
        logic [3:0] be;
        int nb, off;
        nb  = 1 << sz;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] m_lanes(input logic [1:0] sz,
                                            input logic [31:0] d);
        logic [31:0] r;
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int nb, off;
        logic neg;
        nb  = 1 << sz;
        off = int'(a % 4);
        v   = 32'h0;
        for (int i = 0; i < nb; i++)
            v[8*i +: 8] = rd[8*(off+i) +: 8];
        neg = sg && v[8*nb-1];
        for (int i = nb; i < 4; i++)
            v[8*i +: 8] = neg ? 8'hFF : 8'h00;
        return v;
    endfunction

    // d: strobe cycle (1-based) in which the matching OK is raised; 0 = never.
    task automatic run(input string tag, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int d, input logic stray);
        logic [1:0] ec;
        int ns;
        logic tmo;
        ec  = m_err(sz, a);
        tmo = !(d >= 1 && d <= T);
        ns  = tmo ? T : d;
        chk({tag, ".ready"}, 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
        ReqAddress = a; ReqWriteData = wd;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0; ReqAddress = $urandom; ReqWriteData = $urandom;
        ReqSize = 2'($urandom); ReqSigned = 1'($urandom);
        if (ec != 2'd0) begin
            chk({tag, ".erv"}, 32'(RespValid), 32'd1);
            chk({tag, ".eerr"}, 32'(RespError), 32'd1);
            chk({tag, ".ecode"}, 32'(RespErrorCode), 32'(ec));
            chk({tag, ".edata"}, RespData, 32'h0);
            chk({tag, ".estb"}, {30'h0, ReadAssert, WriteAssert}, 32'h0);
        end else begin
            for (int k = 1; k <= ns; k++) begin
                chk({tag, ".rstb"}, 32'(ReadAssert), 32'(!wr));
                chk({tag, ".wstb"}, 32'(WriteAssert), 32'(wr));
                chk({tag, ".addr"}, AddressBus, {a[31:2], 2'b00});
                chk({tag, ".be"}, 32'(ByteEnable), 32'(m_be(sz, a)));
                if (wr)
                    chk({tag, ".wdata"}, DataWriteBus, m_lanes(sz, wd));
                chk({tag, ".rvlo"}, 32'(RespValid), 32'd0);
                ReadOK  = (!wr && k == d) || (wr && stray);
                WriteOK = (wr && k == d) || (!wr && stray);
                DataReadBus = (k == d) ? rd : $urandom;
                @(negedge clk);
                ReadOK = 1'b0; WriteOK = 1'b0; DataReadBus = $urandom;
            end
            chk({tag, ".rv"}, 32'(RespValid), 32'd1);
            chk({tag, ".err"}, 32'(RespError), 32'(tmo));
            chk({tag, ".code"}, 32'(RespErrorCode), tmo ? 32'd2 : 32'd0);
            chk({tag, ".data"}, RespData,
                (wr || tmo) ? 32'h0 : m_load(sz, sg, a, rd));
            chk({tag, ".stb"}, {30'h0, ReadAssert, WriteAssert}, 32'h0);
        end
        @(negedge clk);
        chk({tag, ".rv0"}, 32'(RespValid), 32'd0);
        chk({tag, ".d0"}, RespData, 32'h0);
        chk({tag, ".c0"}, 32'(RespErrorCode), 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0;
        ReqSigned = 1'b0; ReqAddress = '0; ReqWriteData = 32'h0;
        DataReadBus = 32'h0; ReadOK = 1'b0; WriteOK = 1'b0;
        #12;
        chk("rst.ready", 32'(ReqReady), 32'd1);
        chk("rst.rv", 32'(RespValid), 32'd0);
        chk("rst.err", {30'h0, RespError, 1'b0} | 32'(RespErrorCode), 32'h0);
        chk("rst.data", RespData, 32'h0);
        chk("rst.addr", AddressBus, 32'h0);
        chk("rst.wdata", DataWriteBus, 32'h0);
        chk("rst.be", 32'(ByteEnable), 32'h0);
        chk("rst.stb", {30'h0, ReadAssert, WriteAssert}, 32'h0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        run("wload", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        run("sbyte", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1'b0);
        run("ubyte", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1'b0);
        run("hstore", 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 2, 1'b0);
        run("mis", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        run("ill", 1'b0, 2'd3, 1'b0, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        run("tmo", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h11223344, 0, 1'b1);
        run("ok4", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 4, 1'b1);
        run("shalf", 1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 32'h9ABC0000, 2, 1'b0);

        // Reset in the 2nd strobe cycle of a write.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2;
        ReqAddress = 32'h200; ReqWriteData = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("arst.w1", 32'(WriteAssert), 32'd1);
        @(negedge clk);
        chk("arst.w2", 32'(WriteAssert), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("arst.drop", 32'(WriteAssert), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("arst.norv", 32'(RespValid), 32'd0);
            chk("arst.ready", 32'(ReqReady), 32'd1);
            @(negedge clk);
        end
        run("post", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            run("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                int'($urandom_range(0, 6)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
